// File: rtl/desc_streamer_if.sv
// Pixel-memory read port and descriptor word handshake between the streamer
// (master) and the memory/receiver side (slave).
interface desc_streamer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [31:0]       desc_data_out;
  logic              desc_data_ready;
  logic              desc_data_ack;

  modport master (
    output mem_rd, mem_addr, desc_data_out, desc_data_ready,
    input  mem_data, desc_data_ack
  );

  modport slave (
    input  mem_rd, mem_addr, desc_data_out, desc_data_ready,
    output mem_data, desc_data_ack
  );
endinterface

// File: rtl/desc_streamer.sv
// Streams a DESC_DIM x DESC_DIM byte descriptor from pixel memory as packed
// 32-bit words (4 horizontal pixels, row-major) over a ready/ack handshake.
module desc_streamer #(
  parameter int DESC_DIM   = 16,
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  desc_streamer_if.master   bus,
  output logic              busy,
  output logic              done
);
  localparam int GROUPS = DESC_DIM / 4;
  localparam int ROW_W  = (DESC_DIM > 1) ? $clog2(DESC_DIM) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, FILL, PRESENT, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ROW_W-1:0]  row;
  logic [GRP_W-1:0]  grp;
  logic [1:0]        k;
  logic              rd_d;
  logic [23:0]       assembly;

  logic              grp_last;
  logic              word_last;
  logic [GRP_W-1:0]  grp_nxt;
  logic [ROW_W-1:0]  row_nxt;

  assign grp_last  = (grp == GRP_W'(GROUPS - 1));
  assign word_last = grp_last && (row == ROW_W'(DESC_DIM - 1));
  assign grp_nxt   = grp_last ? '0 : grp + GRP_W'(1);
  assign row_nxt   = grp_last ? row + ROW_W'(1) : row;

  // {grp, k} is exactly grp*4 + k; the sum wraps at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
                                                input logic [ROW_W-1:0]  r,
                                                input logic [GRP_W-1:0]  g,
                                                input logic [1:0]        kk);
    return b + ADDR_W'(r) * ADDR_W'(ROW_STRIDE) + ADDR_W'({g, kk});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      base                <= '0;
      row                 <= '0;
      grp                 <= '0;
      k                   <= '0;
      rd_d                <= 1'b0;
      assembly            <= '0;
      bus.mem_rd          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.desc_data_out   <= '0;
      bus.desc_data_ready <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_d <= bus.mem_rd;
      // Read data trails the strobe by one cycle, so the delayed strobe marks valid bytes.
      if (rd_d) assembly <= {assembly[15:0], bus.mem_data};

      if (abort && state != IDLE) begin
        state               <= IDLE;
        row                 <= '0;
        grp                 <= '0;
        k                   <= '0;
        bus.mem_rd          <= 1'b0;
        bus.desc_data_ready <= 1'b0;
        busy                <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base         <= base_addr;
              row          <= '0;
              grp          <= '0;
              k            <= '0;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= addr_of(base_addr, '0, '0, 2'd0);
              busy         <= 1'b1;
              state        <= FETCH;
            end
          end
          FETCH: begin
            if (k == 2'd3) begin
              bus.mem_rd <= 1'b0;
              state      <= FILL;
            end else begin
              k            <= k + 2'd1;
              bus.mem_addr <= addr_of(base, row, grp, k + 2'd1);
            end
          end
          FILL: begin
            // The fourth byte arrives this cycle, so it bypasses the assembly register.
            bus.desc_data_out   <= {assembly, bus.mem_data};
            bus.desc_data_ready <= 1'b1;
            state               <= PRESENT;
          end
          PRESENT: begin
            if (bus.desc_data_ack) begin
              bus.desc_data_ready <= 1'b0;
              grp                 <= grp_nxt;
              row                 <= row_nxt;
              if (word_last) begin
                done  <= 1'b1;
                state <= FIN;
              end else begin
                k            <= '0;
                bus.mem_rd   <= 1'b1;
                bus.mem_addr <= addr_of(base, row_nxt, grp_nxt, 2'd0);
                state        <= FETCH;
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_desc_streamer.sv
// Directed/randomised bench for desc_streamer: a byte-array memory plus an
// address/word reference computed from row-major descriptor arithmetic.
module tb_desc_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, busy, done;
  logic [15:0] base_addr;
  desc_streamer_if #(.ADDR_W(16)) m_if ();

  logic        s_start, s_abort, s_busy, s_done;
  logic [15:0] s_base;
  desc_streamer_if #(.ADDR_W(16)) s_if ();

  desc_streamer #(.DESC_DIM(16), .ADDR_W(16), .ROW_STRIDE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .bus(m_if), .busy(busy), .done(done)
  );

  desc_streamer #(.DESC_DIM(16), .ADDR_W(16), .ROW_STRIDE(640)) dut_stride (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .base_addr(s_base), .bus(s_if), .busy(s_busy), .done(s_done)
  );

  logic [7:0]  mem_arr [0:65535];
  logic [31:0] got [0:63];
  logic [15:0] s_addrs [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) m_if.mem_data <= mem_arr[m_if.mem_addr];
  assign s_if.mem_data      = 8'h00;
  assign s_if.desc_data_ack = s_if.desc_data_ready;
  always @(negedge clk) if (s_if.mem_rd) s_addrs.push_back(s_if.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] b, input int stride,
                                           input int n, input int k);
    return 16'(int'(b) + (n / 4) * stride + (n % 4) * 4 + k);
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] b, input int n);
    return {mem_arr[exp_addr(b, 16, n, 0)], mem_arr[exp_addr(b, 16, n, 1)],
            mem_arr[exp_addr(b, 16, n, 2)], mem_arr[exp_addr(b, 16, n, 3)]};
  endfunction

  task automatic mem_identity();
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'(i);
  endtask

  task automatic mem_random();
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
  endtask

  // One transfer; stall_word/abort_word of -1 disables that behaviour.
  task automatic do_transfer(input logic [15:0] base, input int stall_word,
                             input int stall_len, input bit stray, input int abort_word);
    int n, k, c_start, stall_left, hold_cnt;
    bit seen_ready, finished, aborting;
    logic [31:0] held;
    n = 0; k = 0; stall_left = stall_len; hold_cnt = 0;
    seen_ready = 0; finished = 0; aborting = 0; held = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; c_start = cyc;
    for (int t = 0; t < 1000 && !finished; t++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; m_if.desc_data_ack = 1'b0;
      if (aborting) begin
        chk("abort_busy", busy, 0);
        chk("abort_ready", m_if.desc_data_ready, 0);
        chk("abort_mem_rd", m_if.mem_rd, 0);
        chk("abort_no_done", done, 0);
        finished = 1;
      end else begin
        if (t == 0) chk("busy_rise", busy, 1);
        if (m_if.mem_rd) begin
          chk("rd_addr", m_if.mem_addr, exp_addr(base, 16, n, k));
          k++;
        end
        if (done) begin
          chk("done_cycle", cyc - c_start, 385 + ((stall_word >= 0) ? stall_len : 0));
          chk("ack_count", n, 64);
          finished = 1;
        end else if (m_if.desc_data_ready) begin
          hold_cnt++;
          if (!seen_ready) begin
            seen_ready = 1; held = m_if.desc_data_out; got[n] = m_if.desc_data_out;
            chk("word", m_if.desc_data_out, exp_word(base, n));
            chk("reads_per_word", k, 4);
          end else begin
            chk("hold_data", m_if.desc_data_out, held);
          end
          if (n == stall_word && stall_left > 0) begin
            stall_left--;
          end else begin
            if (n == stall_word) chk("stall_ready_cycles", hold_cnt, stall_len + 1);
            m_if.desc_data_ack = 1'b1;
            if (n == abort_word) begin
              abort = 1'b1;
              aborting = 1;
            end
            n++; k = 0; seen_ready = 0; hold_cnt = 0;
          end
        end else if (stray) begin
          m_if.desc_data_ack = 1'($urandom_range(0, 1));
          if (busy) start = 1'($urandom_range(0, 1));
        end
      end
    end
    start = 1'b0; abort = 1'b0; m_if.desc_data_ack = 1'b0;
    if (!finished) chk("transfer_timeout", 0, 1);
    if (!aborting) begin
      @(negedge clk);
      chk("busy_fall", busy, 0);
      chk("done_pulse_end", done, 0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, m_if.desc_data_ready, 0);
    chk({tag, "_mem_rd"}, m_if.mem_rd, 0);
    chk({tag, "_mem_addr"}, m_if.mem_addr, 0);
    chk({tag, "_data"}, m_if.desc_data_out, 0);
  endtask

  initial begin
    logic [15:0] b;
    bit s_fin;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
    m_if.desc_data_ack = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_base = '0;
    mem_identity();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Stride instance: 640-byte rows from base 0x0100, acks immediate.
    @(negedge clk);
    s_start = 1'b1; s_base = 16'h0100;
    @(negedge clk);
    s_start = 1'b0;
    s_fin = 0;
    for (int t = 0; t < 1000 && !s_fin; t++) begin
      @(negedge clk);
      if (s_done) s_fin = 1;
    end
    chk("stride_done", s_fin, 1);
    chk("stride_reads", s_addrs.size(), 256);
    if (s_addrs.size() == 256) begin
      for (int i = 0; i < 256; i++)
        chk("stride_addr", s_addrs[i], exp_addr(16'h0100, 640, i / 4, i % 4));
      chk("stride_row1_grp0", s_addrs[16], 16'h0380);
      chk("stride_row15_grp3", s_addrs[255], 16'h268F);
    end

    // Basic transfer, identity memory.
    do_transfer(16'h0000, -1, 0, 0, -1);
    chk("basic_w0", got[0], 32'h00010203);
    chk("basic_w1", got[1], 32'h04050607);
    chk("basic_w4", got[4], 32'h10111213);
    chk("basic_w63", got[63], 32'hFCFDFEFF);

    // Backpressure on word 7, random memory and base.
    mem_random();
    b = 16'($urandom);
    do_transfer(b, 7, 5, 0, -1);

    // Stray ack/start pulses, base near the top so addresses wrap.
    b = 16'hFF00 | 16'($urandom_range(0, 255));
    do_transfer(b, -1, 0, 1, -1);

    // Abort together with ack on word 20, then restart from word 0.
    mem_identity();
    do_transfer(16'h0000, -1, 0, 0, 20);
    do_transfer(16'h0000, -1, 0, 0, -1);
    chk("restart_w0", got[0], 32'h00010203);

    // Asynchronous reset while a word is presented, then a clean transfer.
    mem_random();
    b = 16'($urandom);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (m_if.desc_data_ready) break;
      @(negedge clk);
    end
    chk("reached_present", m_if.desc_data_ready, 1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    b = 16'($urandom);
    do_transfer(b, -1, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
